terrain_crater: RTL
===================

// Module: terrain_crater
// PURPOSE
//  Read-modify-write engine that carves a circular crater into the column-major terrain SRAM after a shell impact.
//  Sits between the projectile/collision logic (issues start + centre + radius) and the terrain store's write port
//  (terrain_in/write_addr/we) and read port (read_addr -> terrain_out). Column bit y = 1 means solid, 0 means air.
// PARAMETERS
//  NCOLS  640  number of terrain columns (valid x = 0..NCOLS-1)
//  NROWS  480  bits per column (valid y = 0..NROWS-1)
//  RAD_W  6    radius width; max radius 2^RAD_W-1 = 63
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      1-cycle request; sampled only in IDLE
//  center_x       in   10     crater centre column (unsigned; >=NCOLS allowed, clipped)
//  center_y       in   10     crater centre row (unsigned; >=NROWS allowed, clipped)
//  radius         in   RAD_W  crater radius in pixels
//  terrain_rdata  in   480    column data from terrain store, valid 1 cycle after read_addr
//  read_addr      out  10     column to read
//  write_addr     out  10     column to write
//  we             out  1      write strobe to terrain store
//  terrain_wdata  out  480    modified column
//  busy           out  1      high from cycle after accepted start until done
//  done           out  1      1-cycle pulse when crater finished
// BEHAVIOUR
//  Reset: state=IDLE; read_addr=0, write_addr=0, we=0, terrain_wdata=0, busy=0, done=0; immediately on reset edge.
//  Start captured (cx,cy,r latched) only in IDLE; start while busy ignored, no queueing.
//  FSM: IDLE -> SETUP -> {CHORD -> READ -> WAIT -> WRITE}* -> DONE -> IDLE.
//   SETUP (1 cyc): x_lo = max(cx-r,0), x_hi = min(cx+r,NCOLS-1), signed 11-bit math; x = x_lo;
//     if cx >= NCOLS+r equivalently x_lo > x_hi -> DONE directly, no writes.
//   CHORD: dx = x-cx (signed 11b); h starts at r; each cycle if h^2+dx^2 > r^2 (13-bit unsigned) then h--,
//     else go READ. Takes r-h+1 cycles. h never underflows (|dx|<=r guarantees h=0 passes).
//   READ (1 cyc): read_addr = x. WAIT (1 cyc): terrain_rdata valid at end; capture.
//   WRITE (1 cyc): we=1, write_addr=x, terrain_wdata = rdata with bits y in [cy-h, cy+h] cleared,
//     bounds computed signed 11b then clipped to [0,NROWS-1]; range fully outside -> data unchanged, still written.
//     Then x==x_hi -> DONE else x++ -> CHORD.
//   DONE (1 cyc): done=1, busy=0 next cycle; -> IDLE.
//  we high only in WRITE; one write per column; columns processed strictly ascending.
//  Only clears bits (never sets); bits outside crater pass through unchanged.
//  radius=0: single column cx, only bit cy cleared (if in range).
//  Reset mid-operation: abort at once, we drops, partially carved columns remain; no further writes.
//  Caller is responsible for not issuing start during terrain regeneration; block does not arbitrate.
// STRUCTURE
//  Package terrain_pkg: NCOLS, NROWS, RAD_W constants; crater_state_t enum {IDLE,SETUP,CHORD,READ,WAIT,WRITE,DONE}.
//  Sub-module crater_mask: combinational, (cy,h) -> 480-bit keep-mask (1=keep); top ANDs with rdata.
//  Chord search, address counter and FSM stay in terrain_crater.
// TESTING  (bench models terrain store: 1-cycle read latency, init column = bits 310..479 set)
//  1 start cx=100,cy=310,r=3 -> writes cols 97..103 only; col100 bits 310..313 cleared; col98 bits 310..312;
//    col97 bit 310 only; all other bits unchanged; done pulses once, busy low after.
//  2 cx=1,r=5 -> x_lo clipped to 0, writes cols 0..6 only; cx=638,r=5 -> writes cols 633..639, never addr 640+.
//  3 cy=2,r=4 at cx=50 -> col50 clears bits 0..6, no wrap to bit 479; cy=478,r=4 -> clears 474..479 only.
//  4 r=0,cx=200,cy=400 -> exactly one we, col200 bit 400 cleared; cycle count SETUP+CHORD(1)+READ+WAIT+WRITE+DONE.
//  5 cx=700,r=10 -> SETUP then DONE, zero we pulses; start re-pulsed during busy -> ignored, centre unchanged.
//  6 assert reset during 3rd column WRITE of case 1 -> we=0 and busy=0 same cycle; cols 97..98 carved,
//    99..103 untouched; new start after reset completes normally.

Source files
------------

// File: rtl/terrain_crater_pkg.sv
// Shared constants and state encoding for the crater carving engine.
package terrain_pkg;

   localparam int NCOLS  = 640;
   localparam int NROWS  = 480;
   localparam int RAD_W  = 6;
   localparam int ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CHORD,
      READ,
      WAIT,
      WRITE,
      DONE
   } crater_state_t;

endpackage

// File: rtl/terrain_crater_mask.sv
// Builds the per-column keep-mask for one crater chord: bits within
// [cy-h, cy+h] are 0 (cleared), all other bits are 1 (kept).
module crater_mask
   import terrain_pkg::*;
(
   input  logic [ADDR_W-1:0] cy_i,
   input  logic [RAD_W-1:0]  h_i,
   output logic [NROWS-1:0]  keep_o
);

   int lowRow;
   int highRow;

   // Bounds are held as plain integers, so a range that falls partly or fully
   // outside the column is clipped naturally by the comparisons below.
   assign lowRow  = int'(cy_i) - int'(h_i);
   assign highRow = int'(cy_i) + int'(h_i);

   // Clear every row inside the chord, keep everything else.
   always_comb begin
      keep_o = '1;
      for (int y = 0; y < NROWS; y++) begin
         if ((y >= lowRow) && (y <= highRow)) begin
            keep_o[y] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/terrain_crater.sv
// Read-modify-write engine that carves a circular crater into the
// column-major terrain store, one column at a time in ascending order.
module terrain_crater
   import terrain_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] center_x,
   input  logic [ADDR_W-1:0] center_y,
   input  logic [RAD_W-1:0]  radius,
   input  logic [NROWS-1:0]  terrain_rdata,
   output logic [ADDR_W-1:0] read_addr,
   output logic [ADDR_W-1:0] write_addr,
   output logic              we,
   output logic [NROWS-1:0]  terrain_wdata,
   output logic              busy,
   output logic              done
);

   localparam logic signed [11:0] COL_MAX = 12'(NCOLS - 1);

   crater_state_t     state_q,   state_d;
   logic [ADDR_W-1:0] centerX_q, centerX_d;
   logic [ADDR_W-1:0] centerY_q, centerY_d;
   logic [RAD_W-1:0]  radius_q,  radius_d;
   logic [ADDR_W-1:0] x_q,       x_d;
   logic [ADDR_W-1:0] xHi_q,     xHi_d;
   logic [RAD_W-1:0]  h_q,       h_d;
   logic [NROWS-1:0]  wdata_q,   wdata_d;

   logic signed [11:0] cxS, rS, xLoRaw, xHiRaw, xLoS, xHiS;
   logic signed [12:0] dxS;
   logic [12:0]        dxMag, dxSq, hExt, rExt, hSq, rSq, distSq;
   logic [NROWS-1:0]   keepMask;

   // Column span of the crater, clipped to the terrain. Twelve bits keep
   // cx+r from wrapping when the centre sits past the right edge.
   always_comb begin
      cxS    = $signed({2'b00, centerX_q});
      rS     = $signed({{(12 - RAD_W){1'b0}}, radius_q});
      xLoRaw = cxS - rS;
      xHiRaw = cxS + rS;
      xLoS   = xLoRaw[11] ? 12'sd0 : xLoRaw;
      xHiS   = (xHiRaw > COL_MAX) ? COL_MAX : xHiRaw;
   end

   // Chord test for the current column: h shrinks until h^2 + dx^2 <= r^2.
   // |dx| never exceeds r inside the span, so 13 bits hold every square.
   always_comb begin
      dxS    = $signed({3'b000, x_q}) - $signed({3'b000, centerX_q});
      dxMag  = dxS[12] ? $unsigned(-dxS) : $unsigned(dxS);
      hExt   = {{(13 - RAD_W){1'b0}}, h_q};
      rExt   = {{(13 - RAD_W){1'b0}}, radius_q};
      dxSq   = dxMag * dxMag;
      hSq    = hExt * hExt;
      rSq    = rExt * rExt;
      distSq = hSq + dxSq;
   end

   crater_mask uMask (
      .cy_i   (centerY_q),
      .h_i    (h_q),
      .keep_o (keepMask)
   );

   // State and datapath registers; reset aborts any crater in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         centerX_q <= '0;
         centerY_q <= '0;
         radius_q  <= '0;
         x_q       <= '0;
         xHi_q     <= '0;
         h_q       <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         centerX_q <= centerX_d;
         centerY_q <= centerY_d;
         radius_q  <= radius_d;
         x_q       <= x_d;
         xHi_q     <= xHi_d;
         h_q       <= h_d;
         wdata_q   <= wdata_d;
      end
   end

   // Sequencing: latch the request, find each chord, then read, mask and
   // write back that column before moving one column to the right.
   always_comb begin
      state_d   = state_q;
      centerX_d = centerX_q;
      centerY_d = centerY_q;
      radius_d  = radius_q;
      x_d       = x_q;
      xHi_d     = xHi_q;
      h_d       = h_q;
      wdata_d   = wdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               centerX_d = center_x;
               centerY_d = center_y;
               radius_d  = radius;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (xLoS > xHiS) begin
               state_d = DONE;
            end else begin
               x_d     = xLoS[ADDR_W-1:0];
               xHi_d   = xHiS[ADDR_W-1:0];
               h_d     = radius_q;
               state_d = CHORD;
            end
         end
         CHORD: begin
            if (distSq > rSq) begin
               h_d = h_q - 1'b1;
            end else begin
               state_d = READ;
            end
         end
         READ: begin
            state_d = WAIT;
         end
         WAIT: begin
            wdata_d = terrain_rdata & keepMask;
            state_d = WRITE;
         end
         WRITE: begin
            if (x_q == xHi_q) begin
               state_d = DONE;
            end else begin
               x_d     = x_q + 1'b1;
               h_d     = radius_q;
               state_d = CHORD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign read_addr     = x_q;
   assign write_addr    = x_q;
   assign we            = (state_q == WRITE);
   assign terrain_wdata = wdata_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);

endmodule
